// File: rtl/prng_pkg.sv
// prng_pkg: shared definitions for the LCG pseudo-random generator.
//   DEF_WIDTH / DEF_CNT_W : default operand width and iteration-counter width
//   state_e               : top-level sequencer states
//   operands_ok()         : legality check applied to operands on start
package prng_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ADD  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // Operands are zero-extended to 64 bits so one function serves every WIDTH.
  // A legal set needs m >= 2 and every other operand already reduced mod m,
  // which is what keeps all intermediate sums within WIDTH+1 bits.
  function automatic logic operands_ok(input logic [63:0] m,
                                       input logic [63:0] a,
                                       input logic [63:0] c,
                                       input logic [63:0] seed);
    return (m >= 64'd2) && (a < m) && (c < m) && (seed < m);
  endfunction

endpackage

// File: rtl/prng_lcg_if.sv
// prng_lcg_if: operand / control / result bundle of the LCG generator.
//   m, a, c, seed : modulus, multiplier, increment, initial state (to DUT)
//   start, cont   : load-and-run / next-value requests (to DUT)
//   done, busy    : result-valid level / computation in progress (from DUT)
//   err           : operands rejected at last start (from DUT)
//   rand_val      : current generator output (from DUT)
//   count         : values produced since last accepted start (from DUT)
// master = requester side, slave = generator side.
interface prng_lcg_if #(
  parameter int WIDTH = prng_pkg::DEF_WIDTH,
  parameter int CNT_W = prng_pkg::DEF_CNT_W
) ();

  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] seed;
  logic             start;
  logic             cont;
  logic             done;
  logic             busy;
  logic             err;
  logic [WIDTH-1:0] rand_val;
  logic [CNT_W-1:0] count;

  modport master (
    output m, a, c, seed, start, cont,
    input  done, busy, err, rand_val, count
  );

  modport slave (
    input  m, a, c, seed, start, cont,
    output done, busy, err, rand_val, count
  );

endinterface

// File: rtl/prng_modmul.sv
// prng_modmul: bit-serial interleaved modular multiplier, r = (a * x) mod m.
//   clk, rst : clock, async active-high reset
//   start    : load m, a, x and begin; one bit of a is consumed per cycle
//   m, a, x  : operands, sampled only on start (a < m, x < m expected)
//   last     : high during the cycle that processes bit 0 of a
//   r        : running / final residue; final once the cycle after last
// Takes exactly WIDTH cycles from the start edge to the final residue.
module prng_modmul
  import prng_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] x,
  output logic             last,
  output logic [WIDTH-1:0] r
);

  localparam int               IDX_W   = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] r_q, r_d;

  logic [WIDTH:0]   dbl;
  logic [WIDTH:0]   dbl_red;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   acc_red;
  logic [WIDTH-1:0] r_step;

  // One Horner step. r < m and x < m, so 2r and (2r mod m) + x both stay
  // below 2m and a single conditional subtract reduces each of them.
  always_comb begin
    dbl     = {r_q, 1'b0};
    dbl_red = (dbl >= {1'b0, m_q}) ? dbl - {1'b0, m_q} : dbl;
    acc     = dbl_red + {1'b0, x_q};
    acc_red = (acc >= {1'b0, m_q}) ? acc - {1'b0, m_q} : acc;
    r_step  = a_q[WIDTH-1] ? WIDTH'(acc_red) : WIDTH'(dbl_red);
  end

  // a_q is shifted left each cycle so its MSB is always the current bit;
  // idx_q is a down-counter whose terminal count marks the last bit.
  always_comb begin
    busy_d = busy_q;
    idx_d  = idx_q;
    m_d    = m_q;
    a_d    = a_q;
    x_d    = x_q;
    r_d    = r_q;
    if (start) begin
      busy_d = 1'b1;
      idx_d  = IDX_TOP;
      m_d    = m;
      a_d    = a;
      x_d    = x;
      r_d    = '0;
    end else if (busy_q) begin
      r_d   = r_step;
      a_d   = a_q << 1;
      idx_d = idx_q - IDX_W'(1);
      if (idx_q == '0) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
      m_q    <= '0;
      a_q    <= '0;
      x_q    <= '0;
      r_q    <= '0;
    end else begin
      busy_q <= busy_d;
      idx_q  <= idx_d;
      m_q    <= m_d;
      a_q    <= a_d;
      x_q    <= x_d;
      r_q    <= r_d;
    end
  end

  assign last = busy_q && (idx_q == '0);
  assign r    = r_q;

endmodule

// File: rtl/prng_lcg.sv
// prng_lcg: linear congruential generator x(n+1) = (a*x(n) + c) mod m.
//   clk, rst : clock, async active-high reset
//   bus      : prng_lcg_if slave port (operands, start/cont, results)
// The multiply runs in prng_modmul (WIDTH cycles), followed by one ADD
// cycle, so done rises WIDTH+1 edges after the accepting edge.
//
// state | meaning
// IDLE  | no valid result; waiting for start (cont ignored)
// MUL   | modmul consuming bits of a, MSB first
// ADD   | add c mod m, publish rand, bump count
// HOLD  | result valid (done=1); start reloads, cont computes next value
module prng_lcg
  import prng_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic       clk,
  input logic       rst,
  prng_lcg_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] rand_q, rand_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic             mul_start;
  logic [WIDTH-1:0] mul_m;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_x;
  logic             mul_last;
  logic [WIDTH-1:0] mul_r;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] add_res;
  logic             ops_legal;

  prng_modmul #(
    .WIDTH (WIDTH)
  ) u_modmul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .m     (mul_m),
    .a     (mul_a),
    .x     (mul_x),
    .last  (mul_last),
    .r     (mul_r)
  );

  assign ops_legal = operands_ok(64'(bus.m), 64'(bus.a), 64'(bus.c), 64'(bus.seed));

  // mul_r < m and c < m, so one conditional subtract completes the mod.
  always_comb begin
    add_sum = {1'b0, mul_r} + {1'b0, c_q};
    add_res = (add_sum >= {1'b0, m_q}) ? WIDTH'(add_sum - {1'b0, m_q}) : WIDTH'(add_sum);
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    c_d       = c_q;
    rand_d    = rand_q;
    count_d   = count_q;
    err_d     = err_q;
    mul_start = 1'b0;
    // cont reuses the registered operands with the current output as x
    mul_m     = m_q;
    mul_a     = a_q;
    mul_x     = rand_q;

    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (bus.start) begin
          if (ops_legal) begin
            m_d       = bus.m;
            a_d       = bus.a;
            c_d       = bus.c;
            count_d   = '0;
            err_d     = 1'b0;
            state_d   = ST_MUL;
            mul_start = 1'b1;
            mul_m     = bus.m;
            mul_a     = bus.a;
            mul_x     = bus.seed;
          end else begin
            // rand and count deliberately keep their previous values
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if ((state_q == ST_HOLD) && bus.cont) begin
          state_d   = ST_MUL;
          mul_start = 1'b1;
        end
      end

      ST_MUL: begin
        if (mul_last) begin
          state_d = ST_ADD;
        end
      end

      ST_ADD: begin
        rand_d  = add_res;
        count_d = count_q + CNT_W'(1);
        state_d = ST_HOLD;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      a_q     <= '0;
      c_q     <= '0;
      rand_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      c_q     <= c_d;
      rand_q  <= rand_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.done     = (state_q == ST_HOLD);
  assign bus.busy     = (state_q == ST_MUL) || (state_q == ST_ADD);
  assign bus.err      = err_q;
  assign bus.rand_val = rand_q;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_prng_lcg.sv
module tb_prng_lcg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prng_lcg_if #(.WIDTH(8),  .CNT_W(16)) i8  ();
  prng_lcg_if #(.WIDTH(32), .CNT_W(16)) i32 ();

  prng_lcg #(.WIDTH(8),  .CNT_W(16)) dut8  (.clk(clk), .rst(rst), .bus(i8));
  prng_lcg #(.WIDTH(32), .CNT_W(16)) dut32 (.clk(clk), .rst(rst), .bus(i32));

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0] m;
    logic [7:0] a;
    logic [7:0] c;
    logic [7:0] seed;
    int         n_cont;
    logic [7:0] exp_rand;
    int         exp_count;
    bit         exp_err;
  } vec_t;

  // reference: the LCG recurrence in wide plain arithmetic
  function automatic logic [63:0] lcg_next(input logic [63:0] m, input logic [63:0] a,
                                           input logic [63:0] c, input logic [63:0] x);
    logic [127:0] p;
    p = 128'(a) * 128'(x) + 128'(c);
    return 64'(p % 128'(m));
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start8(input logic [7:0] m, input logic [7:0] a,
                        input logic [7:0] c, input logic [7:0] seed);
    i8.m = m; i8.a = a; i8.c = c; i8.seed = seed;
    i8.start = 1'b1;
    tick();
    i8.start = 1'b0;
  endtask

  task automatic cont8();
    i8.cont = 1'b1;
    tick();
    i8.cont = 1'b0;
  endtask

  task automatic wait_done8(output int edges);
    edges = 0;
    while (!i8.done && edges < 200) begin
      tick();
      edges++;
    end
    if (!i8.done) chk("done8_timeout", i8.done, 1);
  endtask

  task automatic wait_done32(output int edges);
    edges = 0;
    while (!i32.done && edges < 200) begin
      tick();
      edges++;
    end
    if (!i32.done) chk("done32_timeout", i32.done, 1);
  endtask

  initial begin
    vec_t        tbl [8];
    int          seq [7];
    int          e;
    int          nc;
    bit          bad;
    logic [63:0] mm, aa, cc, xx, mr;
    int          mn;

    seq = '{3, 2, 6, 4, 5, 1, 3};
    tbl[0] = '{8'd16,  8'd5,   8'd3,   8'd0,   3, 8'd4, 4, 1'b0};
    tbl[1] = '{8'd1,   8'd0,   8'd0,   8'd0,   0, 8'd0, 0, 1'b1};
    tbl[2] = '{8'd255, 8'd254, 8'd254, 8'd254, 0, 8'd0, 1, 1'b0};
    tbl[3] = '{8'd10,  8'd10,  8'd0,   8'd0,   0, 8'd0, 0, 1'b1};
    tbl[4] = '{8'd2,   8'd1,   8'd1,   8'd1,   1, 8'd1, 2, 1'b0};
    tbl[5] = '{8'd10,  8'd3,   8'd10,  8'd0,   0, 8'd0, 0, 1'b1};
    tbl[6] = '{8'd200, 8'd199, 8'd0,   8'd199, 0, 8'd1, 1, 1'b0};
    tbl[7] = '{8'd7,   8'd3,   8'd0,   8'd1,   6, 8'd3, 7, 1'b0};

    rst = 1'b1;
    i8.m = '0;  i8.a = '0;  i8.c = '0;  i8.seed = '0;  i8.start = 1'b0;  i8.cont = 1'b0;
    i32.m = '0; i32.a = '0; i32.c = '0; i32.seed = '0; i32.start = 1'b0; i32.cont = 1'b0;
    repeat (2) tick();
    chk("rst_rand",  i8.rand_val, 0);
    chk("rst_count", i8.count, 0);
    chk("rst_err",   i8.err, 0);
    chk("rst_done",  i8.done, 0);
    chk("rst_busy",  i8.busy, 0);
    rst = 1'b0;
    tick();

    // cont in IDLE does nothing
    cont8();
    chk("idle_cont_busy",  i8.busy, 0);
    chk("idle_cont_count", i8.count, 0);
    tick();
    chk("idle_cont_done",  i8.done, 0);

    // Park-Miller reference point at WIDTH=32
    i32.m = 32'd2147483647; i32.a = 32'd16807; i32.c = 32'd0; i32.seed = 32'd1346601079;
    i32.start = 1'b1;
    tick();
    i32.start = 1'b0;
    wait_done32(e);
    chk("w32_latency", e, 33);
    chk("w32_rand",    i32.rand_val, 32'd2141662667);
    chk("w32_count",   i32.count, 1);

    for (int t = 0; t < 3; t++) begin
      mm = 64'($urandom_range(2, 32'hFFFF_FFFF));
      aa = 64'($urandom) % mm;
      cc = 64'($urandom) % mm;
      xx = 64'($urandom) % mm;
      i32.m = 32'(mm); i32.a = 32'(aa); i32.c = 32'(cc); i32.seed = 32'(xx);
      i32.start = 1'b1;
      tick();
      i32.start = 1'b0;
      wait_done32(e);
      xx = lcg_next(mm, aa, cc, xx);
      chk("w32_rnd_x1", i32.rand_val, xx);
      i32.cont = 1'b1;
      tick();
      i32.cont = 1'b0;
      wait_done32(e);
      xx = lcg_next(mm, aa, cc, xx);
      chk("w32_rnd_x2",    i32.rand_val, xx);
      chk("w32_rnd_count", i32.count, 2);
    end

    // directed table at WIDTH=8
    for (int i = 0; i < 8; i++) begin
      start8(tbl[i].m, tbl[i].a, tbl[i].c, tbl[i].seed);
      if (tbl[i].exp_err) begin
        chk("tbl_err",      i8.err, 1);
        chk("tbl_err_done", i8.done, 0);
        chk("tbl_err_busy", i8.busy, 0);
      end else begin
        chk("tbl_err_clr", i8.err, 0);
        wait_done8(e);
        chk("tbl_latency", e, 9);
        for (int k = 0; k < tbl[i].n_cont; k++) begin
          cont8();
          wait_done8(e);
        end
        chk("tbl_rand",  i8.rand_val, tbl[i].exp_rand);
        chk("tbl_count", i8.count, tbl[i].exp_count);
      end
    end

    // cont held high free-runs: m=7 a=3 c=0 seed=1
    start8(8'd7, 8'd3, 8'd0, 8'd1);
    wait_done8(e);
    chk("run_x1", i8.rand_val, seq[0]);
    i8.cont = 1'b1;
    for (int k = 1; k < 7; k++) begin
      tick();
      chk("run_done_width", i8.done, 0);
      wait_done8(e);
      chk("run_spacing", e + 1, 10);
      chk("run_val", i8.rand_val, seq[k]);
    end
    i8.cont = 1'b0;
    chk("run_count", i8.count, 7);

    // rejected starts keep rand/count; a legal start clears err
    start8(8'd1, 8'd0, 8'd0, 8'd0);
    chk("rej_m1_err",   i8.err, 1);
    chk("rej_m1_done",  i8.done, 0);
    chk("rej_m1_rand",  i8.rand_val, 3);
    chk("rej_m1_count", i8.count, 7);
    start8(8'd9, 8'd2, 8'd1, 8'd9);
    chk("rej_seed_err",  i8.err, 1);
    chk("rej_seed_busy", i8.busy, 0);
    start8(8'd9, 8'd2, 8'd1, 8'd4);
    chk("rej_clear_err", i8.err, 0);
    wait_done8(e);
    chk("rej_clear_rand", i8.rand_val, lcg_next(9, 2, 1, 4));

    // start and cont together in HOLD: start wins
    i8.m = 8'd11; i8.a = 8'd7; i8.c = 8'd2; i8.seed = 8'd5;
    i8.start = 1'b1; i8.cont = 1'b1;
    tick();
    i8.start = 1'b0; i8.cont = 1'b0;
    wait_done8(e);
    mr = lcg_next(11, 7, 2, 5);
    chk("both_rand",  i8.rand_val, mr);
    chk("both_count", i8.count, 1);

    // cont and operand changes during busy are ignored
    cont8();
    repeat (3) tick();
    chk("busy_mid", i8.busy, 1);
    i8.m = 8'd3; i8.a = 8'd2; i8.seed = 8'd1;
    i8.cont = 1'b1;
    tick();
    i8.cont = 1'b0;
    wait_done8(e);
    mr = lcg_next(11, 7, 2, mr);
    chk("busy_rand",  i8.rand_val, mr);
    repeat (12) tick();
    chk("busy_hold_done",  i8.done, 1);
    chk("busy_hold_count", i8.count, 2);

    // asynchronous reset mid-MUL
    start8(8'd13, 8'd6, 8'd5, 8'd3);
    repeat (4) tick();
    chk("arst_pre_busy", i8.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_rand",  i8.rand_val, 0);
    chk("arst_count", i8.count, 0);
    chk("arst_err",   i8.err, 0);
    chk("arst_done",  i8.done, 0);
    chk("arst_busy",  i8.busy, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_post_done", i8.done, 0);
    start8(8'd100, 8'd37, 8'd11, 8'd42);
    wait_done8(e);
    mr = lcg_next(100, 37, 11, 42);
    mn = 1;
    chk("arst_new_latency", e, 9);
    chk("arst_new_rand",    i8.rand_val, mr);
    chk("arst_new_count",   i8.count, 1);

    // randomized operands against the reference model
    for (int t = 0; t < 30; t++) begin
      mm = 64'($urandom_range(2, 255));
      aa = 64'($urandom_range(0, 32'(mm) - 1));
      cc = 64'($urandom_range(0, 32'(mm) - 1));
      bad = 1'b0;
      if (($urandom_range(0, 4) == 0) && (mm < 255)) begin
        xx  = 64'($urandom_range(32'(mm), 255));
        bad = 1'b1;
      end else begin
        xx = 64'($urandom_range(0, 32'(mm) - 1));
      end
      nc = int'($urandom_range(0, 3));
      start8(8'(mm), 8'(aa), 8'(cc), 8'(xx));
      if (bad) begin
        chk("rnd_rej_err",   i8.err, 1);
        chk("rnd_rej_rand",  i8.rand_val, mr);
        chk("rnd_rej_count", i8.count, mn);
      end else begin
        wait_done8(e);
        mr = lcg_next(mm, aa, cc, xx);
        mn = 1;
        chk("rnd_x1", i8.rand_val, mr);
        for (int k = 0; k < nc; k++) begin
          cont8();
          wait_done8(e);
          mr = lcg_next(mm, aa, cc, mr);
          mn++;
          chk("rnd_xn", i8.rand_val, mr);
        end
        chk("rnd_count", i8.count, mn);
        chk("rnd_below_m", (64'(i8.rand_val) < mm), 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prng_lcg.md
PRNG_LCG -- requirements
Module: prng_lcg

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal 4..64).
REQ-002 Parameter CNT_W, default 16, width of the iteration counter.
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 m  input  WIDTH  modulus; sampled on accepted start.
REQ-006 a  input  WIDTH  multiplier; sampled on accepted start.
REQ-007 c  input  WIDTH  increment (0 gives the Lehmer generator); sampled on accepted start.
REQ-008 seed  input  WIDTH  initial state x0; sampled on accepted start.
REQ-009 start  input  1  load operands and seed, then compute x1.
REQ-010 cont  input  1  compute the next value from the current rand.
REQ-011 done  output  1  level; rand valid, block idle-holding.
REQ-012 busy  output  1  computation in progress.
REQ-013 err  output  1  operands rejected at last start.
REQ-014 rand  output  WIDTH  current value x(n+1) = (a*x(n) + c) mod m.
REQ-015 count  output  CNT_W  values produced since last accepted start; wraps at 2^CNT_W.

Function
REQ-016 FSM states IDLE, MUL, ADD, HOLD; done=1 only in HOLD; busy=1 only in MUL and ADD.
REQ-017 start is accepted in IDLE or HOLD; start has priority over cont in the same cycle.
REQ-018 On accept: register m, a, c, seed; clear count and err; enter MUL with bit index WIDTH-1 and r=0.
REQ-019 Reject instead (err=1, go to IDLE, rand and count unchanged) if m<2, a>=m, c>=m or seed>=m.
REQ-020 MUL: one bit of a per cycle, MSB first: r = 2r mod m, then r = (r + x) mod m if a[i]=1; intermediates WIDTH+1 bits, no wider multiplier.
REQ-021 After bit 0, go to ADD; ADD computes (r + c) mod m, writes rand and x, increments count, enters HOLD.
REQ-022 Latency: done rises WIDTH+1 clock edges after the edge that accepted start or cont.
REQ-023 cont is sampled only in HOLD when start=0; it re-enters MUL with x=rand and reuses the registered m, a, c.
REQ-024 cont held high free-runs: one new value every WIDTH+2 cycles, with done high for exactly 1 cycle each.
REQ-025 start or cont while busy=1 is ignored; inputs m, a, c, seed changing mid-computation have no effect.
REQ-026 cont in IDLE is ignored.
REQ-027 All results satisfy rand < m.

Reset
REQ-028 Asserting rst forces state IDLE, rand=0, count=0, err=0, done=0, busy=0, r=0, immediately and without a clock edge.
REQ-029 Reset mid-computation aborts it; the first start after deassertion behaves as if from power-up.

Structure
REQ-030 Package prng_pkg holds the state enum, the default WIDTH and CNT_W, and the operand-check function.
REQ-031 Sub-module prng_modmul (bit-serial interleaved modular multiplier with start/done) holds the MUL datapath; prng_lcg holds the FSM, the ADD step and the counters.

Verification
REQ-032 WIDTH=32, m=2147483647, a=16807, c=0, seed=1346601079, start pulse -> done after 33 edges, rand=2141662667, count=1.
REQ-033 WIDTH=8, m=7, a=3, c=0, seed=1, start then cont held high -> rand sequence 3,2,6,4,5,1,3; done pulses spaced 10 cycles apart.
REQ-034 WIDTH=8, m=16, a=5, c=3, seed=0, start then 3 cont pulses -> rand 3,2,13,4; count=4.
REQ-035 m=1, or seed=m, with start -> err=1, done=0, state IDLE; a following legal start clears err.
REQ-036 rst asserted mid-MUL -> all outputs 0 asynchronously; start with new operands yields the correct first value.
REQ-037 start and cont both high in HOLD -> new seed loaded and count=1; cont pulsed during busy -> no extra value produced.
